pal_macrocell: RTL and testbench

Parametrised programmable array logic block with an on-chip configuration loader and per-output macrocells. A serial configuration stream programs an AND plane over true and complemented inputs, an OR plane, and per-output invert and register-select bits. It is the next-generation PAL core of the easy_PAL design, sitting between the external configuration pin and user logic.

---
 rtl/pal_macrocell.sv | 130 +++++++++++++
 tb/tb_pal_macrocell.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_macrocell.sv
// Serially configured PAL core: AND/OR planes with per-output invert/register macrocells.
// Define PAL_READBACK_EN to expose chain bit 0 on CFG_OUT for readback and daisy-chaining.
module pal_macrocell #(
    parameter int N = 8,
    parameter int M = 8,
    parameter int P = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CFG_START,
    input  logic         CFG_DATA,
    output logic         CFG_BUSY,
    output logic         CFG_DONE,
    output logic         ARMED,
    input  logic [N-1:0] INPUT_VARS,
`ifdef PAL_READBACK_EN
    output logic         CFG_OUT,
`endif
    output logic [M-1:0] OUTPUT_VALS
);

    localparam int A       = 2 * N * P;
    localparam int B       = A + M * P;
    localparam int CFG_LEN = B + 2 * M;
    localparam int CW      = $clog2(CFG_LEN);
    localparam logic [CW-1:0] LAST = CW'(CFG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CFG_LEN-1:0]   chain_q, chain_d;
    logic                 done_q, done_d;
    logic [M-1:0]         mreg_q, mreg_d;

    logic [2*N-1:0]       lit;
    logic [2*N-1:0]       and_bits;
    logic [P-1:0]         term;
    logic [M-1:0]         sum;
    logic [M-1:0]         v;
    logic [M-1:0]         reg_sel;

    always_comb begin
        lit      = '0;
        and_bits = '0;
        term     = '0;
        sum      = '0;
        v        = '0;
        reg_sel  = '0;
        for (int i = 0; i < N; i++) begin
            lit[2*i]   = INPUT_VARS[i];
            lit[2*i+1] = ~INPUT_VARS[i];
        end
        // An empty product term must read 0, not the AND identity.
        for (int p = 0; p < P; p++) begin
            and_bits = chain_q[p*2*N +: 2*N];
            term[p]  = (|and_bits) & (&(lit | ~and_bits));
        end
        for (int m = 0; m < M; m++) begin
            sum[m]     = |(term & chain_q[A+m*P +: P]);
            v[m]       = sum[m] ^ chain_q[B+2*m];
            reg_sel[m] = chain_q[B+2*m+1];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chain_d = chain_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (CFG_START) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                chain_d = {CFG_DATA, chain_q[CFG_LEN-1:1]};
                if (CFG_START) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (CFG_START) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        mreg_d = (state_q == RUN && state_d == RUN) ? v : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            chain_q <= '0;
            done_q  <= 1'b0;
            mreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chain_q <= chain_d;
            done_q  <= done_d;
            mreg_q  <= mreg_d;
        end
    end

    assign ARMED       = (state_q == RUN);
    assign CFG_BUSY    = (state_q == LOAD);
    assign CFG_DONE    = done_q;
    assign OUTPUT_VALS = ARMED ? ((reg_sel & mreg_q) | (~reg_sel & v)) : '0;

`ifdef PAL_READBACK_EN
    assign CFG_OUT = chain_q[0];
`endif

endmodule

// File: tb/tb_pal_macrocell.sv
// Bench for pal_macrocell at N=M=P=2 (16-bit chain): model-based per-cycle
// compare plus directed literal expectations.
module tb_pal_macrocell;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CFG_START = 1'b0;
    logic       CFG_DATA = 1'b0;
    logic       CFG_BUSY;
    logic       CFG_DONE;
    logic       ARMED;
    logic [1:0] INPUT_VARS = 2'b00;
    logic [1:0] OUTPUT_VALS;
    logic       cfg_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    pal_macrocell #(.N(2), .M(2), .P(2)) dut (
        .CLK(CLK),
        .RST(RST),
        .CFG_START(CFG_START),
        .CFG_DATA(CFG_DATA),
        .CFG_BUSY(CFG_BUSY),
        .CFG_DONE(CFG_DONE),
        .ARMED(ARMED),
        .INPUT_VARS(INPUT_VARS),
`ifdef PAL_READBACK_EN
        .CFG_OUT(cfg_out),
`endif
        .OUTPUT_VALS(OUTPUT_VALS)
    );

`ifndef PAL_READBACK_EN
    assign cfg_out = 1'b0;
`endif

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=idle 1=load 2=run; mcfg holds the bits the chain should contain.
    int         mmode = 0;
    int         mbits = 0;
    logic [15:0] mcfg = '0;
    logic       mdone = 1'b0;
    logic [1:0] mreg = '0;

    function automatic logic [1:0] eval_v(input logic [15:0] c, input logic [1:0] in);
        logic [3:0] lits;
        logic [1:0] t;
        logic [1:0] r;
        lits = {~in[1], in[1], ~in[0], in[0]};
        for (int p = 0; p < 2; p++) begin
            bit any_set = 0;
            bit all_true = 1;
            for (int l = 0; l < 4; l++) begin
                if (c[p*4+l]) begin
                    any_set = 1;
                    if (!lits[l]) all_true = 0;
                end
            end
            t[p] = any_set && all_true;
        end
        for (int m = 0; m < 2; m++) begin
            bit s = 0;
            for (int p = 0; p < 2; p++)
                if (c[8+m*2+p] && t[p]) s = 1;
            r[m] = s ^ c[12+2*m];
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_out();
        logic [1:0] v;
        logic [1:0] r;
        r = '0;
        if (mmode == 2) begin
            v = eval_v(mcfg, INPUT_VARS);
            for (int m = 0; m < 2; m++)
                r[m] = mcfg[13+2*m] ? mreg[m] : v[m];
        end
        return r;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            mmode = 0;
            mbits = 0;
            mcfg  = '0;
            mdone = 1'b0;
            mreg  = '0;
        end else begin
            logic [1:0] nreg;
            nreg  = (mmode == 2 && !CFG_START) ? eval_v(mcfg, INPUT_VARS) : 2'b00;
            mdone = 1'b0;
            if (mmode == 1) begin
                mcfg = {CFG_DATA, mcfg[15:1]};
                if (CFG_START) begin
                    mbits = 0;
                end else begin
                    mbits = mbits + 1;
                    if (mbits == 16) begin
                        mmode = 2;
                        mdone = 1'b1;
                    end
                end
            end else if (CFG_START) begin
                mmode = 1;
                mbits = 0;
            end
            mreg = nreg;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cyc_out", OUTPUT_VALS, exp_out());
            chk("cyc_busy", CFG_BUSY, mmode == 1);
            chk("cyc_done", CFG_DONE, mdone);
            chk("cyc_armed", ARMED, mmode == 2);
`ifdef PAL_READBACK_EN
            chk("cyc_cfg_out", cfg_out, mcfg[0]);
`endif
        end
    end

    task automatic cyc(input logic s, input logic d);
        CFG_START = s;
        CFG_DATA  = d;
        @(negedge CLK);
        #1;
    endtask

    task automatic load(input logic [15:0] cfg, output int lat, output logic [15:0] rb);
        cyc(1'b1, 1'b0);
        chk("load_busy", CFG_BUSY, 1'b1);
        chk("load_armed_drop", ARMED, 1'b0);
        rb    = '0;
        rb[0] = cfg_out;
        lat   = -1;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, cfg[i]);
            if (CFG_DONE === 1'b1 && lat < 0) lat = i + 1;
            if (i < 15) rb[i+1] = cfg_out;
        end
    endtask

    logic [1:0] comb_in [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] comb_ex [4] = '{2'b00, 2'b01, 2'b00, 2'b00};

    initial begin
        int lat;
        logic [15:0] rb;
        @(negedge CLK);
        #1;
        chk_en = 1;

        for (int i = 0; i < 4; i++) begin
            INPUT_VARS = 2'(i);
            cyc(1'b1, 1'b1);
            chk("rst_out", OUTPUT_VALS, 2'b00);
            chk("rst_armed", ARMED, 1'b0);
            chk("rst_busy", CFG_BUSY, 1'b0);
            chk("rst_done", CFG_DONE, 1'b0);
        end
        RST = 1'b0;
        INPUT_VARS = 2'b00;
        cyc(1'b0, 1'b1);
        chk("idle_busy", CFG_BUSY, 1'b0);

        load(16'h0109, lat, rb);
        chk("comb_lat", lat, 16);
        chk("comb_armed", ARMED, 1'b1);
        for (int i = 0; i < 4; i++) begin
            INPUT_VARS = comb_in[i];
            #1;
            chk("comb_out", OUTPUT_VALS, comb_ex[i]);
            cyc(1'b0, 1'b1);
        end

        INPUT_VARS = 2'b00;
        load(16'h2109, lat, rb);
        chk("reg_lat", lat, 16);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        INPUT_VARS = 2'b01;
        #1;
        chk("reg_before", OUTPUT_VALS, 2'b00);
        cyc(1'b0, 1'b0);
        chk("reg_after", OUTPUT_VALS, 2'b01);
        INPUT_VARS = 2'b11;
        #1;
        chk("reg_hold", OUTPUT_VALS, 2'b01);
        cyc(1'b0, 1'b0);
        chk("reg_fall", OUTPUT_VALS, 2'b00);

        load(16'h4000, lat, rb);
        chk("inv_lat", lat, 16);
        for (int i = 0; i < 4; i++) begin
            INPUT_VARS = 2'(i);
            #1;
            chk("inv_out", OUTPUT_VALS, 2'b10);
            cyc(1'b0, 1'b0);
        end

        cyc(1'b1, 1'b0);
        repeat (7) cyc(1'b0, 1'b1);
        RST = 1'b1;
        cyc(1'b0, 1'b1);
        RST = 1'b0;
        chk("midrst_busy", CFG_BUSY, 1'b0);
        chk("midrst_done", CFG_DONE, 1'b0);
        chk("midrst_armed", ARMED, 1'b0);
        cyc(1'b0, 1'b0);
        chk("midrst_idle", CFG_DONE, 1'b0);
        cyc(1'b1, 1'b0);
        repeat (5) cyc(1'b0, 1'b1);
        load(16'h0109, lat, rb);
        chk("restart_lat", lat, 16);
        INPUT_VARS = 2'b01;
        #1;
        chk("restart_out", OUTPUT_VALS, 2'b01);
        cyc(1'b0, 1'b0);

`ifdef PAL_READBACK_EN
        load(16'hA5C3, lat, rb);
        load(16'h0000, lat, rb);
        chk("readback", rb, 16'hA5C3);
        chk("readback_lat", lat, 16);
`endif

        repeat (3) cyc(1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
